// File: rtl/spi_master_tx_axil.sv
// Purpose : AXI-Lite write slave that frames each TXDATA write as one SPI word (CPOL/CPHA/bit order/CS via CTRL).
// Latency : TXDATA cs_n falls at T0+2, bvalid at T0+2+CLK_DIV*(2*DATA_W+2); CTRL/error bvalid at T0+2.
// Backpressure: one write in flight; awready/wready stay low from accept until the B handshake completes.
//
// Ports: clk/reset (sync, active-high); axi_lite_aw*/w*/b* write channel (wstrb ignored,
//        awaddr[3:0] decoded: 0x0 TXDATA, 0x4 CTRL, else SLVERR); spi_sclk/spi_mosi/spi_cs_n
//        registered SPI outputs; busy high from write accept until the B handshake.
// Option : `define SPI_MASTER_MODE_SEL_EN makes CTRL bits 0-2 (CPOL, CPHA, LSB_FIRST) live;
//          without it the block is fixed to mode 0 MSB-first and only the CS index is writable.
module spi_master_tx_axil #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       axi_lite_awaddr,
    input  logic              axi_lite_awvalid,
    output logic              axi_lite_awready,
    input  logic [31:0]       axi_lite_wdata,
    input  logic [3:0]        axi_lite_wstrb,
    input  logic              axi_lite_wvalid,
    output logic              axi_lite_wready,
    output logic [1:0]        axi_lite_bresp,
    output logic              axi_lite_bvalid,
    input  logic              axi_lite_bready,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic [NUM_CS-1:0] spi_cs_n,
    output logic              busy
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HP_W  = $clog2(2 * DATA_W);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(2 * DATA_W - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_RESP
    } state_t;

    state_t            state;
    logic [3:0]        addr_q;
    logic [31:0]       wdata_q;
    logic [DATA_W-1:0] sreg;
    logic [CNT_W-1:0]  div_cnt;
    logic [HP_W-1:0]   half_cnt;
    logic [2:0]        cs_idx;
    logic              cpol_eff, cpha_eff, lsb_eff;
    logic [DATA_W-1:0] data_in, load_shift, next_shift;
    logic              load_bit, next_bit;
    logic [NUM_CS-1:0] cs_sel_n;
    logic              leading;
    logic              unused_inputs;

`ifdef SPI_MASTER_MODE_SEL_EN
    logic ctrl_cpol, ctrl_cpha, ctrl_lsb;
    assign cpol_eff = ctrl_cpol;
    assign cpha_eff = ctrl_cpha;
    assign lsb_eff  = ctrl_lsb;
`else
    assign cpol_eff = 1'b0;
    assign cpha_eff = 1'b0;
    assign lsb_eff  = 1'b0;
`endif

    // Both channels must be valid together; accepting them in one cycle keeps AW/W paired.
    assign axi_lite_awready = (state == S_IDLE) && !reset && axi_lite_awvalid && axi_lite_wvalid;
    assign axi_lite_wready  = axi_lite_awready;

    assign unused_inputs = ^{axi_lite_wstrb, axi_lite_awaddr[31:4], wdata_q};
    assign data_in       = wdata_q[DATA_W-1:0];
    // Even half-period index ends on a leading SCLK edge, odd on a trailing one.
    assign leading       = ~half_cnt[0];

    always_comb begin
        load_bit   = lsb_eff ? data_in[0] : data_in[DATA_W-1];
        load_shift = lsb_eff ? (data_in >> 1) : (data_in << 1);
        next_bit   = lsb_eff ? sreg[0] : sreg[DATA_W-1];
        next_shift = lsb_eff ? (sreg >> 1) : (sreg << 1);
        cs_sel_n   = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (3'(i) == cs_idx) cs_sel_n[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            sreg            <= '0;
            div_cnt         <= '0;
            half_cnt        <= '0;
            cs_idx          <= '0;
            axi_lite_bvalid <= 1'b0;
            axi_lite_bresp  <= RESP_OKAY;
            busy            <= 1'b0;
            spi_sclk        <= 1'b0;
            spi_mosi        <= 1'b0;
            spi_cs_n        <= '1;
`ifdef SPI_MASTER_MODE_SEL_EN
            ctrl_cpol       <= 1'b0;
            ctrl_cpha       <= 1'b0;
            ctrl_lsb        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    spi_sclk <= cpol_eff;
                    if (axi_lite_awvalid && axi_lite_wvalid) begin
                        addr_q  <= axi_lite_awaddr[3:0];
                        wdata_q <= axi_lite_wdata;
                        busy    <= 1'b1;
                        state   <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    case (addr_q)
                        4'h0: begin
                            spi_cs_n       <= cs_sel_n;
                            div_cnt        <= '0;
                            axi_lite_bresp <= RESP_OKAY;
                            // CPHA=0 presents the first bit before the first edge.
                            if (!cpha_eff) begin
                                spi_mosi <= load_bit;
                                sreg     <= load_shift;
                            end else begin
                                sreg     <= data_in;
                            end
                            state <= S_CS_SETUP;
                        end
                        4'h4: begin
                            if (32'(wdata_q[6:4]) < NUM_CS) begin
                                cs_idx         <= wdata_q[6:4];
                                axi_lite_bresp <= RESP_OKAY;
`ifdef SPI_MASTER_MODE_SEL_EN
                                ctrl_cpol      <= wdata_q[0];
                                ctrl_cpha      <= wdata_q[1];
                                ctrl_lsb       <= wdata_q[2];
                                spi_sclk       <= wdata_q[0];
`endif
                            end else begin
                                axi_lite_bresp <= RESP_SLVERR;
                            end
                            axi_lite_bvalid <= 1'b1;
                            state           <= S_RESP;
                        end
                        default: begin
                            axi_lite_bresp  <= RESP_SLVERR;
                            axi_lite_bvalid <= 1'b1;
                            state           <= S_RESP;
                        end
                    endcase
                end
                S_CS_SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        half_cnt <= '0;
                        state    <= S_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        spi_sclk <= ~spi_sclk;
                        // CPHA=1 launches on leading edges; CPHA=0 on trailing edges
                        // except the final one, after which no bits remain.
                        if (cpha_eff ? leading : (!leading && half_cnt != HP_LAST)) begin
                            spi_mosi <= next_bit;
                            sreg     <= next_shift;
                        end
                        if (half_cnt == HP_LAST) begin
                            state <= S_CS_HOLD;
                        end else begin
                            half_cnt <= half_cnt + HP_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                S_CS_HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt         <= '0;
                        spi_cs_n        <= '1;
                        axi_lite_bvalid <= 1'b1;
                        state           <= S_RESP;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (axi_lite_bready) begin
                        axi_lite_bvalid <= 1'b0;
                        busy            <= 1'b0;
                        state           <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_tx_axil.sv
module tb_spi_master_tx_axil;

    localparam int LAT_TX = 74;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = 4'hF;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic        spi_sclk;
    logic        spi_mosi;
    logic [0:0]  spi_cs_n;
    logic        busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // SPI line monitor, sampled on the falling clk edge
    int          rise_cnt = 0, fall_cnt = 0, cs_fall_cnt = 0;
    int          cs_fall_cyc = 0, cs_rise_cyc = 0;
    logic [31:0] cap = '0;
    logic [31:0] dir_hist = '0;
    logic        prev_sclk = 1'b0;
    logic        prev_cs = 1'b1;

    spi_master_tx_axil dut (
        .clk              (clk),
        .reset            (reset),
        .axi_lite_awaddr  (awaddr),
        .axi_lite_awvalid (awvalid),
        .axi_lite_awready (awready),
        .axi_lite_wdata   (wdata),
        .axi_lite_wstrb   (wstrb),
        .axi_lite_wvalid  (wvalid),
        .axi_lite_wready  (wready),
        .axi_lite_bresp   (bresp),
        .axi_lite_bvalid  (bvalid),
        .axi_lite_bready  (bready),
        .spi_sclk         (spi_sclk),
        .spi_mosi         (spi_mosi),
        .spi_cs_n         (spi_cs_n),
        .busy             (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (spi_sclk !== prev_sclk) begin
            dir_hist = {dir_hist[30:0], spi_sclk};
            if (spi_sclk === 1'b1) begin
                rise_cnt = rise_cnt + 1;
                cap = {cap[30:0], spi_mosi};
            end else begin
                fall_cnt = fall_cnt + 1;
            end
        end
        if (spi_cs_n[0] !== prev_cs) begin
            if (spi_cs_n[0] === 1'b0) begin
                cs_fall_cnt = cs_fall_cnt + 1;
                cs_fall_cyc = cyc;
            end else begin
                cs_rise_cyc = cyc;
            end
        end
        prev_sclk = spi_sclk;
        prev_cs   = spi_cs_n[0];
    end

    // Drives one AW/W pair with bready high; reports handshake cycle, bvalid latency and bresp.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            output int t0, output int lat, output logic [1:0] resp, output bit ok);
        ok = 1'b0; t0 = -1; lat = -1; resp = 2'b11;
        @(posedge clk); #1;
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready === 1'b1 && wready === 1'b1) begin
                t0 = cyc; ok = 1'b1; break;
            end
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (bvalid === 1'b1) begin
                    lat = cyc - t0; resp = bresp; ok = 1'b1; break;
                end
            end
            @(posedge clk); #1;
        end
        bready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (awready !== 1'b0) begin fails++; $display("FAIL reset_awready_held: got %b want 0", awready); end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, bresp, busy} !== 6'b0) begin
            fails++; $display("FAIL reset_axi: got aw%b w%b bv%b br%b busy%b want all 0", awready, wready, bvalid, bresp, busy);
        end
        checks++;
        if ({spi_cs_n, spi_sclk, spi_mosi} !== 3'b100) begin
            fails++; $display("FAIL reset_spi: got cs_n%b sclk%b mosi%b want 1 0 0", spi_cs_n, spi_sclk, spi_mosi);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (awready !== 1'b0 || wready !== 1'b0) begin fails++; $display("FAIL idle_ready: cycle %0d aw%b w%b want 0", i, awready, wready); end
        end
        // Only one of the two valids present: must not be accepted.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            awvalid = (k == 0); wvalid = (k == 1);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                checks++;
                if (awready !== 1'b0 || wready !== 1'b0 || busy !== 1'b0) begin
                    fails++; $display("FAIL single_valid_%0d: aw%b w%b busy%b want 0", k, awready, wready, busy);
                end
            end
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic test_mode0;
        int t0, lat, r0, f0, c0; logic [1:0] resp; bit ok;
        r0 = rise_cnt; f0 = fall_cnt; c0 = cs_fall_cnt;
        do_write(32'h0, 32'h1234_56A5, t0, lat, resp, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL mode0_handshake: timed out"); end
        checks++;
        if (lat != LAT_TX) begin fails++; $display("FAIL mode0_latency: got %0d want %0d", lat, LAT_TX); end
        checks++;
        if (resp !== 2'b00) begin fails++; $display("FAIL mode0_bresp: got %b want 00", resp); end
        checks++;
        if (cap[7:0] !== 8'hA5) begin fails++; $display("FAIL mode0_bits: got %h want a5", cap[7:0]); end
        checks++;
        if (rise_cnt - r0 != 8 || fall_cnt - f0 != 8) begin
            fails++; $display("FAIL mode0_edges: got rise %0d fall %0d want 8 8", rise_cnt - r0, fall_cnt - f0);
        end
        checks++;
        if (cs_fall_cnt - c0 != 1 || cs_fall_cyc - t0 != 2) begin
            fails++; $display("FAIL mode0_cs: got falls %0d at T0+%0d want 1 at T0+2", cs_fall_cnt - c0, cs_fall_cyc - t0);
        end
        @(negedge clk);
        checks++;
        if (spi_cs_n !== 1'b1 || busy !== 1'b0 || spi_sclk !== 1'b0) begin
            fails++; $display("FAIL mode0_after: got cs_n%b busy%b sclk%b want 1 0 0", spi_cs_n, busy, spi_sclk);
        end
    endtask

    task automatic test_ctrl_mode;
        int t0, lat, r0, f0; logic [1:0] resp; bit ok;
        logic exp_idle, exp_first_rise;
        logic [7:0] exp_bits;
`ifdef SPI_MASTER_MODE_SEL_EN
        exp_idle = 1'b1; exp_first_rise = 1'b0; exp_bits = 8'h80;
`else
        exp_idle = 1'b0; exp_first_rise = 1'b1; exp_bits = 8'h01;
`endif
        do_write(32'h4, 32'h0000_0007, t0, lat, resp, ok);
        checks++;
        if (!ok || lat != 2 || resp !== 2'b00) begin
            fails++; $display("FAIL ctrl_write: got ok%0d lat %0d resp %b want 1 2 00", ok, lat, resp);
        end
        @(negedge clk);
        checks++;
        if (spi_sclk !== exp_idle) begin fails++; $display("FAIL ctrl_sclk_idle: got %b want %b", spi_sclk, exp_idle); end
        r0 = rise_cnt; f0 = fall_cnt;
        do_write(32'h0, 32'h0000_0001, t0, lat, resp, ok);
        checks++;
        if (!ok || lat != LAT_TX || resp !== 2'b00) begin
            fails++; $display("FAIL ctrl_tx_resp: got ok%0d lat %0d resp %b want 1 %0d 00", ok, lat, resp, LAT_TX);
        end
        checks++;
        if (cap[7:0] !== exp_bits) begin fails++; $display("FAIL ctrl_tx_bits: got %h want %h", cap[7:0], exp_bits); end
        checks++;
        if (fall_cnt - f0 != 8 || rise_cnt - r0 != 8) begin
            fails++; $display("FAIL ctrl_tx_edges: got fall %0d rise %0d want 8 8", fall_cnt - f0, rise_cnt - r0);
        end
        checks++;
        if (dir_hist[15] !== exp_first_rise) begin fails++; $display("FAIL ctrl_first_edge: got rising=%b want %b", dir_hist[15], exp_first_rise); end
        @(negedge clk);
        checks++;
        if (spi_sclk !== exp_idle) begin fails++; $display("FAIL ctrl_sclk_end: got %b want %b", spi_sclk, exp_idle); end
    endtask

    // Runs with CTRL = 0x07 still in place from test_ctrl_mode.
    task automatic test_errors;
        int t0, lat, r0, f0, c0; logic [1:0] resp; bit ok;
        logic [7:0] exp_bits;
`ifdef SPI_MASTER_MODE_SEL_EN
        exp_bits = 8'h80;
`else
        exp_bits = 8'h01;
`endif
        do_write(32'h4, 32'h0000_0030, t0, lat, resp, ok);
        checks++;
        if (!ok || lat != 2 || resp !== 2'b10) begin
            fails++; $display("FAIL bad_cs_resp: got ok%0d lat %0d resp %b want 1 2 10", ok, lat, resp);
        end
        c0 = cs_fall_cnt;
        do_write(32'h0, 32'h0000_0001, t0, lat, resp, ok);
        checks++;
        if (cap[7:0] !== exp_bits || cs_fall_cnt - c0 != 1) begin
            fails++; $display("FAIL ctrl_unchanged: got bits %h cs falls %0d want %h 1", cap[7:0], cs_fall_cnt - c0, exp_bits);
        end
        r0 = rise_cnt; f0 = fall_cnt; c0 = cs_fall_cnt;
        do_write(32'h8, 32'h0000_00FF, t0, lat, resp, ok);
        checks++;
        if (!ok || lat != 2 || resp !== 2'b10) begin
            fails++; $display("FAIL unmapped_resp: got ok%0d lat %0d resp %b want 1 2 10", ok, lat, resp);
        end
        checks++;
        if (rise_cnt != r0 || fall_cnt != f0 || cs_fall_cnt != c0) begin
            fails++; $display("FAIL unmapped_quiet: got sclk edges %0d cs falls %0d want 0 0", rise_cnt - r0 + fall_cnt - f0, cs_fall_cnt - c0);
        end
        do_write(32'h4, 32'h0000_0000, t0, lat, resp, ok);
        checks++;
        if (!ok || resp !== 2'b00) begin fails++; $display("FAIL ctrl_restore: got ok%0d resp %b want 1 00", ok, resp); end
    endtask

    task automatic test_back_to_back;
        int t0, t1, tb, lat, held, viol, rise1, c0; bit ok;
        logic [1:0] resp;
        @(posedge clk); #1;
        awaddr = 32'h0; wdata = 32'h3C; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        ok = 1'b0; t0 = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready === 1'b1 && wready === 1'b1) begin t0 = cyc; ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        wdata = 32'h96;                 // second request kept pending
        viol = 0; tb = -1;
        for (int i = 0; i < 200 && ok; i++) begin
            @(negedge clk);
            if (bvalid === 1'b1) begin tb = cyc; break; end
            if (awready !== 1'b0 || wready !== 1'b0 || busy !== 1'b1) viol++;
        end
        checks++;
        if (!ok || tb - t0 != LAT_TX) begin fails++; $display("FAIL b2b_first_latency: got %0d want %0d", tb - t0, LAT_TX); end
        checks++;
        if (viol != 0) begin fails++; $display("FAIL b2b_stall: got %0d cycles ready/not-busy want 0", viol); end
        held = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bvalid === 1'b1 && bresp === 2'b00 && awready === 1'b0) held++;
        end
        checks++;
        if (held != 5) begin fails++; $display("FAIL b2b_bvalid_hold: got %0d cycles want 5", held); end
        rise1 = cs_rise_cyc; c0 = cs_fall_cnt;
        bready = 1'b1;
        ok = 1'b0; t1 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready === 1'b1 && wready === 1'b1) begin t1 = cyc; ok = 1'b1; break; end
        end
        checks++;
        if (!ok || t1 != tb + 6) begin fails++; $display("FAIL b2b_second_accept: got cycle %0d want %0d", t1, tb + 6); end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        lat = -1; resp = 2'b11;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bvalid === 1'b1) begin lat = cyc - t1; resp = bresp; break; end
        end
        @(posedge clk); #1; bready = 1'b0;
        checks++;
        if (lat != LAT_TX || resp !== 2'b00 || cap[7:0] !== 8'h96) begin
            fails++; $display("FAIL b2b_second_word: got lat %0d resp %b bits %h want %0d 00 96", lat, resp, cap[7:0], LAT_TX);
        end
        checks++;
        if (cs_fall_cnt - c0 != 1 || cs_fall_cyc - rise1 < 2) begin
            fails++; $display("FAIL b2b_cs_gap: got %0d cycles high want >= 2", cs_fall_cyc - rise1);
        end
    endtask

    task automatic test_reset_mid;
        int t0, lat, r0, bv; logic [1:0] resp; bit ok;
        r0 = rise_cnt;
        @(posedge clk); #1;
        awaddr = 32'h0; wdata = 32'hFF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready === 1'b1 && wready === 1'b1) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rise_cnt - r0 == 4) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || spi_mosi !== 1'b1 || spi_cs_n !== 1'b0) begin
            fails++; $display("FAIL midreset_reach: got ok%0d mosi%b cs_n%b want 1 1 0", ok, spi_mosi, spi_cs_n);
        end
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({spi_cs_n, spi_sclk, spi_mosi, bvalid, busy} !== 5'b10000) begin
            fails++; $display("FAIL midreset_outputs: got cs_n%b sclk%b mosi%b bv%b busy%b want 1 0 0 0 0", spi_cs_n, spi_sclk, spi_mosi, bvalid, busy);
        end
        bv = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bvalid !== 1'b0 || spi_cs_n !== 1'b1) bv++;
        end
        checks++;
        if (bv != 0) begin fails++; $display("FAIL midreset_no_resp: got %0d active cycles want 0", bv); end
        bready = 1'b0;
        do_write(32'h0, 32'h0000_00A5, t0, lat, resp, ok);
        checks++;
        if (!ok || lat != LAT_TX || resp !== 2'b00 || cap[7:0] !== 8'hA5) begin
            fails++; $display("FAIL midreset_next: got ok%0d lat %0d resp %b bits %h want 1 %0d 00 a5", ok, lat, resp, cap[7:0], LAT_TX);
        end
    endtask

    initial begin
        test_reset;
        test_mode0;
        test_ctrl_mode;
        test_errors;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/spi_master_tx_axil.md
# spi_master_tx_axil

Parametrised SPI master transmitter with an AXI-Lite write slave front end. It succeeds the fixed 8-bit, externally-ticked SPI sender with the following additions:
- configurable word width and chip-select count;
- internally generated SCLK;
- runtime CPOL/CPHA and chip-select selection;
- defined SLVERR responses.

It sits between the AXI-Lite interconnect and off-chip SPI slaves. Each accepted TXDATA write produces exactly one framed SPI word.

## Interface
Parameters:
- DATA_W, default 8: SPI word width in bits; legal range 1–32; taken from wdata[DATA_W-1:0].
- CLK_DIV, default 4: clk cycles per SCLK half-period; must be ≥1.
- NUM_CS, default 1: number of chip-select lines; legal range 1–8.

Ports:
- clk, in, 1: single clock; all logic on rising edge.
- reset, in, 1: synchronous, active-high reset.
- axi_lite_awaddr, in, 32: write address; bits [3:0] decoded.
- axi_lite_awvalid / axi_lite_awready, in / out, 1: address handshake.
- axi_lite_wdata, in, 32: write data.
- axi_lite_wstrb, in, 4: ignored.
- axi_lite_wvalid / axi_lite_wready, in / out, 1: data handshake.
- axi_lite_bresp, out, 2: 00 = OKAY, 10 = SLVERR.
- axi_lite_bvalid / axi_lite_bready, out / in, 1: response handshake.
- spi_sclk, out, 1: serial clock; idles at CPOL.
- spi_mosi, out, 1: serial data out.
- spi_cs_n, out, NUM_CS: active-low chip selects.
- busy, out, 1: high from write accept until the B handshake completes.

## Operation
Register map (offset = awaddr[3:0]):
- 0x0 TXDATA: write starts a transfer.
- 0x4 CTRL (write-only):
  - bit0 = CPOL;
  - bit1 = CPHA;
  - bit2 = LSB_FIRST;
  - bits[6:4] = CS index.
- Any other offset: SLVERR, no side effect.

State machine: IDLE → ACCEPT → {RESP | CS_SETUP → SHIFT → CS_HOLD → RESP} → IDLE.
- IDLE:
  - awready and wready are both driven high only when awvalid and wvalid are both high, so both handshakes complete in the same cycle (T0).
  - awaddr and wdata are latched at T0.
- ACCEPT (one cycle), decode:
  - TXDATA: go to CS_SETUP.
  - CTRL: update CTRL, bresp = 00, go to RESP.
  - CTRL with CS index ≥ NUM_CS: CTRL unchanged, bresp = 10, go to RESP.
  - Unmapped offset: bresp = 10, go to RESP.
- CS_SETUP (CLK_DIV cycles):
  - spi_cs_n[cs_idx] is low; SCLK is at CPOL.
  - If CPHA=0, the first bit is driven on mosi on entry.
- SHIFT (2·CLK_DIV·DATA_W cycles):
  - SCLK toggles every CLK_DIV cycles.
  - CPHA=0: mosi changes on trailing edges.
  - CPHA=1: mosi changes on leading edges.
  - Bit order is MSB-first unless LSB_FIRST is set.
- CS_HOLD (CLK_DIV cycles):
  - SCLK is at CPOL; cs_n remains asserted.
  - On exit, all cs_n are driven high.
- RESP:
  - bvalid is held high with bresp stable until bready.
  - Returns to IDLE in the cycle after the handshake.

Boundary rules:
- CTRL is never changed mid-transfer. No new AW/W is accepted while busy; the master is stalled by awready/wready being low.
- awvalid without wvalid, or the reverse, is not accepted; the block waits in IDLE.
- bready held high before bvalid is asserted: the handshake completes in the first cycle bvalid is high.
- DATA_W < 32: upper wdata bits are ignored.

## Timing
- Reset values:
  - awready = 0, wready = 0, bvalid = 0, bresp = 00, busy = 0;
  - spi_sclk = 0, spi_mosi = 0, spi_cs_n = all ones;
  - CTRL = 0 (mode 0, MSB-first, CS 0).
- Reset asserted mid-operation aborts the transfer immediately:
  - all outputs take reset values on the next edge;
  - no B response is issued.
- All SPI outputs are registered.
- TXDATA latency: with T0 as the handshake cycle, cs_n falls at T0+2 and bvalid rises at T0+2+CLK_DIV·(2·DATA_W+2). For defaults this is T0+74.
- CTRL or error latency: bvalid rises at T0+2.
- Back-to-back transfers: cs_n is deasserted for at least 2 cycles between words.

## Configuration
- SPI_MASTER_MODE_SEL_EN:
  - Defined: CTRL bits 0–2 function as above.
  - Undefined: CPOL = 0, CPHA = 0 and MSB-first are fixed; CTRL bits 0–2 are ignored; CTRL bits [6:4] (CS index) remain functional.

## Test plan
- Reset then idle: after reset is released, cs_n = all ones, sclk = 0, awready = 0; awready/wready stay 0 with no valids present.
- Mode 0 TXDATA write, wdata = 0xA5, defaults:
  - mosi sampled on rising SCLK reads 1,0,1,0,0,1,0,1;
  - exactly 8 rising edges;
  - bvalid at T0+74 with bresp = 00.
- CTRL = 0x07 (CPOL=1, CPHA=1, LSB-first), then TXDATA = 0x01:
  - sclk idles high;
  - first bit 1, sampled on the rising (trailing) edge;
  - 8 falling edges.
- CTRL with CS index 3 and NUM_CS = 1 → bresp = 10 and CTRL unchanged; a write to offset 0x8 → bresp = 10 with no SPI activity.
- Second AW/W presented while busy:
  - awready stays 0 until the first B handshake completes (bready held low for 5 cycles, so bvalid is held for those 5 cycles);
  - the second word then transfers normally.
- Reset pulsed at mid-SHIFT (bit 4 of 0xFF):
  - next cycle cs_n = 1, sclk = CPOL, bvalid = 0;
  - the next write behaves as after a fresh reset.
